// File: rtl/sw_bounce_pkg.sv
// Shared types and constants for the switch bounce emulator.
package sw_bounce_pkg;

  // Controller states: settled level, or inside a bounce window.
  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  // Feedback taps of x^16+x^14+x^13+x^11+1 (state bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  function automatic logic [15:0] fix_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/sw_bounce_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step when step_i is high.
module lfsr16
  import sw_bounce_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic clk,
  input  logic arst,
  input  logic step_i,
  output logic next_bit_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Feedback bit doubles as the new bit 0 once a step is taken.
  always_comb begin
    fb         = ^(lfsr_q & LFSR_TAPS);
    lfsr_d     = lfsr_q;
    if (step_i) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
    next_bit_o = fb;
  end

  // State register, reset to the (non-zero) seed.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lfsr_q <= fix_seed(SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sw_bounce_gen.sv
// Mechanical switch bounce emulator: follows a clean level and inserts a
// bounded burst of pseudo-random glitches after every level change.
module sw_bounce_gen
  import sw_bounce_pkg::*;
#(
  parameter int          CLK_FREQ   = 200_000_000,
  parameter int          BOUNCE_MS  = 5,
  parameter int          TOGGLE_DIV = 1024,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       clean,
  input  logic       en,
  output logic       bouncy,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam int WIN_CYC = CLK_FREQ / 1000 * BOUNCE_MS;
  localparam int CW      = $clog2(WIN_CYC + 1);
  localparam int PW      = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;

  state_t          state_q, state_d;
  logic            level_q, level_d;
  logic            target_q, target_d;
  logic            bouncy_q, bouncy_d;
  logic [7:0]      glitch_q, glitch_d;
  logic [CW-1:0]   win_q, win_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic            step;
  logic            next_bit;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .arst      (arst),
    .step_i    (step),
    .next_bit_o(next_bit)
  );

  // Next-state logic. A tick always advances the LFSR and the glitch count
  // while bouncing; a retrigger or the window end then overrides the level
  // that the tick would have put on bouncy.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    bouncy_d = bouncy_q;
    glitch_d = glitch_q;
    win_d    = win_q;
    presc_d  = presc_q;
    tick     = 1'b0;
    step     = 1'b0;

    if (!en) begin
      state_d  = IDLE;
      bouncy_d = clean;
      level_d  = clean;
    end else begin
      case (state_q)
        IDLE: begin
          if (clean != level_q) begin
            state_d  = BOUNCE;
            target_d = clean;
            bouncy_d = clean;
            win_d    = CW'(WIN_CYC - 1);
            presc_d  = '0;
            glitch_d = 8'd0;
          end
        end
        BOUNCE: begin
          tick    = (presc_q == PW'(TOGGLE_DIV - 1));
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            step = 1'b1;
            if (next_bit) begin
              bouncy_d = ~bouncy_q;
              if (glitch_q != 8'hFF) begin
                glitch_d = glitch_q + 8'd1;
              end
            end
          end
          if (clean != target_q) begin
            target_d = clean;
            bouncy_d = clean;
            win_d    = CW'(WIN_CYC - 1);
          end else if (win_q == '0) begin
            bouncy_d = target_q;
            level_d  = target_q;
            state_d  = IDLE;
          end else begin
            win_d = win_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      level_q  <= 1'b0;
      target_q <= 1'b0;
      bouncy_q <= 1'b0;
      glitch_q <= 8'd0;
      win_q    <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      bouncy_q <= bouncy_d;
      glitch_q <= glitch_d;
      win_q    <= win_d;
      presc_q  <= presc_d;
    end
  end

  assign bouncy     = bouncy_q;
  assign busy       = (state_q == BOUNCE);
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Directed bench for sw_bounce_gen: a 1000-cycle window with three instances
// (default seed, zero seed, TOGGLE_DIV=1) driven by the same inputs.
module tb_sw_bounce_gen;

  logic       clk = 1'b0;
  logic       arst;
  logic       clean;
  logic       en;
  logic       a_bouncy, a_busy;
  logic [7:0] a_cnt;
  logic       z_bouncy, z_busy;
  logic [7:0] z_cnt;
  logic       t_bouncy, t_busy;
  logic [7:0] t_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Glitch counts left behind by the modelled window, reused later.
  logic [7:0] last_cnt_a;
  logic [7:0] last_cnt_t;

  sw_bounce_gen #(.CLK_FREQ(1_000_000), .BOUNCE_MS(1), .TOGGLE_DIV(4), .LFSR_SEED(16'hACE1))
    dut_a (.clk(clk), .arst(arst), .clean(clean), .en(en),
           .bouncy(a_bouncy), .busy(a_busy), .glitch_cnt(a_cnt));

  sw_bounce_gen #(.CLK_FREQ(1_000_000), .BOUNCE_MS(1), .TOGGLE_DIV(4), .LFSR_SEED(16'h0000))
    dut_z (.clk(clk), .arst(arst), .clean(clean), .en(en),
           .bouncy(z_bouncy), .busy(z_busy), .glitch_cnt(z_cnt));

  sw_bounce_gen #(.CLK_FREQ(1_000_000), .BOUNCE_MS(1), .TOGGLE_DIV(1), .LFSR_SEED(16'hACE1))
    dut_t (.clk(clk), .arst(arst), .clean(clean), .en(en),
           .bouncy(t_bouncy), .busy(t_busy), .glitch_cnt(t_cnt));

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic test_reset();
    arst  = 1'b1;
    en    = 1'b1;
    clean = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({a_bouncy, a_busy, a_cnt, z_bouncy, z_busy, z_cnt, t_bouncy, t_busy, t_cnt} !== 30'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: got a=%b%b%0d z=%b%b%0d t=%b%b%0d, want all zero",
               a_bouncy, a_busy, a_cnt, z_bouncy, z_busy, z_cnt, t_bouncy, t_busy, t_cnt);
    end
    arst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({a_bouncy, a_busy, a_cnt, z_bouncy, z_busy, z_cnt, t_bouncy, t_busy, t_cnt} !== 30'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got a=%b%b%0d z=%b%b%0d t=%b%b%0d, want all zero",
               a_bouncy, a_busy, a_cnt, z_bouncy, z_busy, z_cnt, t_bouncy, t_busy, t_cnt);
    end
  endtask

  // clean 0->1 and a full window, compared cycle by cycle with an LFSR model.
  task automatic test_bounce();
    logic [15:0] sa = 16'hACE1;
    logic [15:0] st = 16'hACE1;
    logic        ba = 1'b1;
    logic        bt = 1'b1;
    logic [7:0]  ca = 8'd0;
    logic [7:0]  ct = 8'd0;
    clean = 1'b1;
    for (int m = 1; m <= 1000; m++) begin
      @(negedge clk);
      tests_run++;
      if ({a_busy, a_bouncy, a_cnt} !== {1'b1, ba, ca}) begin
        tests_failed++;
        $display("[TB] FAIL bounce_a cycle %0d: busy/bouncy/cnt got %b/%b/%0d want 1/%b/%0d",
                 m, a_busy, a_bouncy, a_cnt, ba, ca);
      end
      tests_run++;
      if ({z_busy, z_bouncy, z_cnt} !== {1'b1, ba, ca}) begin
        tests_failed++;
        $display("[TB] FAIL seed0 cycle %0d: busy/bouncy/cnt got %b/%b/%0d want 1/%b/%0d",
                 m, z_busy, z_bouncy, z_cnt, ba, ca);
      end
      tests_run++;
      if ({t_busy, t_bouncy, t_cnt} !== {1'b1, bt, ct}) begin
        tests_failed++;
        $display("[TB] FAIL div1 cycle %0d: busy/bouncy/cnt got %b/%b/%0d want 1/%b/%0d",
                 m, t_busy, t_bouncy, t_cnt, bt, ct);
      end
      // model the edge that ends bounce cycle m
      if (m % 4 == 0) begin
        sa = lfsr_step(sa);
        if (sa[0]) begin
          if (ca != 8'hFF) ca = ca + 8'd1;
          ba = ~ba;
        end
      end
      st = lfsr_step(st);
      if (st[0]) begin
        if (ct != 8'hFF) ct = ct + 8'd1;
        bt = ~bt;
      end
      if (m == 1000) begin
        ba = 1'b1;
        bt = 1'b1;
      end
    end
    @(negedge clk);
    tests_run++;
    if ({a_busy, a_bouncy, a_cnt} !== {1'b0, 1'b1, ca}) begin
      tests_failed++;
      $display("[TB] FAIL bounce_end_a: busy/bouncy/cnt got %b/%b/%0d want 0/1/%0d",
               a_busy, a_bouncy, a_cnt, ca);
    end
    tests_run++;
    if ({z_busy, z_bouncy, z_cnt} !== {1'b0, 1'b1, ca}) begin
      tests_failed++;
      $display("[TB] FAIL bounce_end_seed0: busy/bouncy/cnt got %b/%b/%0d want 0/1/%0d",
               z_busy, z_bouncy, z_cnt, ca);
    end
    tests_run++;
    if ({t_busy, t_bouncy, t_cnt} !== {1'b0, 1'b1, 8'hFF}) begin
      tests_failed++;
      $display("[TB] FAIL div1_saturate: busy/bouncy/cnt got %b/%b/%0d want 0/1/255",
               t_busy, t_bouncy, t_cnt);
    end
    last_cnt_a = ca;
    last_cnt_t = ct;
  endtask

  // en=0: bouncy follows clean one cycle late, busy low, counts frozen.
  task automatic test_transparent();
    logic prev;
    en    = 1'b0;
    clean = 1'b1;
    prev  = clean;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      tests_run++;
      if ({a_bouncy, a_busy, a_cnt} !== {prev, 1'b0, last_cnt_a}) begin
        tests_failed++;
        $display("[TB] FAIL transparent_a step %0d: bouncy/busy/cnt got %b/%b/%0d want %b/0/%0d",
                 i, a_bouncy, a_busy, a_cnt, prev, last_cnt_a);
      end
      tests_run++;
      if ({t_bouncy, t_busy, t_cnt} !== {prev, 1'b0, last_cnt_t}) begin
        tests_failed++;
        $display("[TB] FAIL transparent_t step %0d: bouncy/busy/cnt got %b/%b/%0d want %b/0/%0d",
                 i, t_bouncy, t_busy, t_cnt, prev, last_cnt_t);
      end
      if (i % 3 == 0) clean = ~clean;
      prev = clean;
    end
    clean = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  // clean 0->1, back to 0 on bounce cycle 500: window stretches to 1500.
  task automatic test_retrigger();
    int  busy_cycles = 0;
    bit  seen        = 1'b0;
    bit  done        = 1'b0;
    clean = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({a_busy, a_bouncy} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL retrig_entry: busy/bouncy got %b/%b want 1/1", a_busy, a_bouncy);
    end
    for (int k = 0; k < 3000 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (a_busy) begin
        seen = 1'b1;
        busy_cycles++;
        if (busy_cycles == 500) clean = 1'b0;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    tests_run++;
    if (busy_cycles != 1500 || !done) begin
      tests_failed++;
      $display("[TB] FAIL retrig_length: busy cycles got %0d (ended=%0b) want 1500", busy_cycles, done);
    end
    tests_run++;
    if (a_bouncy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL retrig_final: bouncy got %b want 0", a_bouncy);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests_run++;
      if ({a_busy, a_bouncy} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL retrig_settled %0d: busy/bouncy got %b/%b want 0/0", k, a_busy, a_bouncy);
      end
    end
  endtask

  // arst in the middle of a window clears outputs without waiting for a clock.
  task automatic test_arst_mid_window();
    clean = 1'b1;
    repeat (300) @(negedge clk);
    tests_run++;
    if (a_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL arst_pre: busy got %b want 1", a_busy);
    end
    #2;
    arst = 1'b1;
    #1;
    tests_run++;
    if ({a_bouncy, a_busy, a_cnt, t_bouncy, t_busy, t_cnt} !== 20'd0) begin
      tests_failed++;
      $display("[TB] FAIL arst_async: got a=%b%b%0d t=%b%b%0d want all zero",
               a_bouncy, a_busy, a_cnt, t_bouncy, t_busy, t_cnt);
    end
    clean = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests_run++;
      if ({a_bouncy, a_busy, a_cnt} !== 10'd0) begin
        tests_failed++;
        $display("[TB] FAIL arst_idle %0d: bouncy/busy/cnt got %b/%b/%0d want 0/0/0",
                 k, a_bouncy, a_busy, a_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_transparent();
    test_retrigger();
    test_arst_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sw_bounce_gen.md
# sw_bounce_gen

Synthesizable mechanical-switch bounce emulator, the driving counterpart of the team's switch debouncers. It takes a clean, clock-synchronous level and reproduces it on `bouncy`, inserting a bounded burst of pseudo-random glitches after every level change. Used on-board and in benches as a deterministic stimulus source for debouncer and edge-detector blocks.

## Interface
- `CLK_FREQ`, 200_000_000, clock frequency in Hz.
- `BOUNCE_MS`, 5, bounce window length in ms. `WIN_CYC = CLK_FREQ/1000*BOUNCE_MS`.
- `TOGGLE_DIV`, 1024, clock cycles per toggle opportunity (≥1).
- `LFSR_SEED`, 16'hACE1, LFSR reset value. 0 is replaced by 16'hACE1.

Ports:
- `clk`  input  1  single clock, rising edge.
- `arst`  input  1  asynchronous, active-high reset.
- `clean`  input  1  ideal switch level, synchronous to `clk`.
- `en`  input  1  1: emulate bounce; 0: transparent, registered.
- `bouncy`  output  1  emulated switch contact.
- `busy`  output  1  high while a bounce window is active.
- `glitch_cnt`  output  8  toggles emitted in the current/last window, saturating at 255.

## Operation
- States (shared enum): `IDLE`, `BOUNCE`.
- Internal regs:
  - `level_q` (last settled level)
  - `target`
  - window counter, width `$clog2(WIN_CYC+1)`
  - prescaler, width `$clog2(TOGGLE_DIV)`, min 1
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1
- Reset:
  - outputs: `bouncy`=0, `busy`=0, `glitch_cnt`=0
  - internal: `level_q`=0, state `IDLE`, LFSR=seed
- `en`=0:
  - state forced to `IDLE`; `bouncy <= clean`; `level_q <= clean`
  - `busy`=0; `glitch_cnt` holds; LFSR holds
- `IDLE`, `en`=1, `clean != level_q`:
  - enter `BOUNCE`; `target <= clean`; `bouncy <= clean` (first contact)
  - window counter <= `WIN_CYC-1`; prescaler <= 0; `glitch_cnt <= 0`
- `BOUNCE`, each cycle:
  - prescaler increments; tick when prescaler == `TOGGLE_DIV-1`, then wraps to 0.
  - On tick: LFSR advances one step. If new LFSR bit 0 = 1, `bouncy` inverts and `glitch_cnt` increments (saturating).
  - LFSR advances only on ticks, so the sequence is deterministic per seed.
- Retrigger:
  - `clean != target` during `BOUNCE` → `target <= clean`, `bouncy <= clean`.
  - Window counter reloads to `WIN_CYC-1`. Prescaler, LFSR and `glitch_cnt` continue (no clear).
  - Takes priority over the tick in the same cycle.
- Window end:
  - Condition: window counter == 0 and no retrigger.
  - Actions: `bouncy <= target`, `level_q <= target`, back to `IDLE`.
  - End-of-window assignment overrides a coincident tick toggle.
- `en` falling during `BOUNCE`: abort immediately per the `en`=0 rule.

## Timing
- All outputs registered.
- `clean` change sampled at edge n:
  - `bouncy`=`clean` and `busy`=1 after edge n+1.
  - `busy` high for exactly `WIN_CYC` cycles (no retrigger).
  - `bouncy`=`target` guaranteed from the cycle `busy` falls.
- First toggle opportunity: `TOGGLE_DIV` cycles after entry. Max toggles per window: `floor(WIN_CYC/TOGGLE_DIV)`.
- Transparent mode (`en`=0): 1-cycle latency.
- `arst` assertion mid-window: outputs go to reset values asynchronously. First new window starts ≥1 cycle after deassertion.

## Structure
- `sw_bounce_pkg`: `state_t` enum, LFSR tap constant, default seed constant.
- Sub-module `lfsr16` (step enable, seed parameter, async active-high reset), instantiated once.
- Top holds the FSM, counters and output registers.

## Test plan
Params `CLK_FREQ`=1_000_000, `BOUNCE_MS`=1 (`WIN_CYC`=1000), `TOGGLE_DIV`=4 unless stated.
- Assert `arst` at cycle 300 of a window → `bouncy`, `busy`, `glitch_cnt` = 0 same cycle; deassert with `clean`=0 → stays `IDLE`.
- `en`=1, `clean` 0→1 → `bouncy`=1 next cycle; `busy` high 1000 cycles; `bouncy`=1 afterwards.
  - `glitch_cnt` and `bouncy` toggle times equal a bench LFSR model over 250 ticks.
- `clean` 0→1, then back to 0 at cycle 500 → `busy` high 1500 cycles total; final `bouncy`=0; `level_q` unchanged (no new window after).
- `en`=0, `clean` toggling every 3 cycles → `bouncy` = `clean` delayed 1 cycle; `busy`=0; `glitch_cnt` constant.
- `LFSR_SEED`=0 → trace identical to the seed-16'hACE1 run of the second scenario.
- `TOGGLE_DIV`=1 → `glitch_cnt` saturates at 255 and holds; final `bouncy`=`target`.
